// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu constants and the fetch FSM state type
package cpu_pkg;

  // Bytes per instruction word; the fetch PC advances by this amount
  localparam int unsigned WORD_BYTES = 4;

  // ARM "mov r0, r0", presented to decode when no live instruction is present
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with stall, branch redirect and range halt
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 512,
  parameter logic [31:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic        instr_mem_read_en_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus8_o,
  output logic        if_valid_o,
  output logic        halted_o,
  output logic [31:0] fetch_count_o
);
  import cpu_pkg::*;

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  req_pc_q;
  logic         req_valid_q;
  logic [31:0]  fetch_count_q;
  logic [31:0]  fetch_count_d;

  logic [31:0]  target_aligned;
  logic [32:0]  pc_last_byte;
  logic [32:0]  target_last_byte;
  logic         in_range;
  logic         target_in_range;
  logic         read_en;

  // A word fetch is legal only if its last byte lies inside the memory. The
  // sums are one bit wider so the bound trips before pc arithmetic can wrap.
  assign target_aligned   = branch_target_i & ~32'h0000_0003;
  assign pc_last_byte     = {1'b0, pc_q} + 33'd3;
  assign target_last_byte = {1'b0, target_aligned} + 33'd3;
  assign in_range         = pc_last_byte < 33'(IMEM_BYTES);
  assign target_in_range  = target_last_byte < 33'(IMEM_BYTES);

  // Reads happen only in RUN; a redirect or a stalled decode suppresses them
  assign read_en = (state_q == FETCH_RUN) & ~stall_i & ~branch_taken_i & in_range;

  assign pc_o                = pc_q;
  assign instr_mem_read_en_o = read_en;
  assign if_instr_o          = req_valid_q ? instr_i : NOP_INSTR;
  assign if_pc_o             = req_pc_q;
  assign if_pc_plus8_o       = req_pc_q + 32'd8;
  assign if_valid_o          = req_valid_q;
  assign halted_o            = (state_q == FETCH_HALT);
  assign fetch_count_o       = fetch_count_q;

  // Fetch sequencer: boot delay, linear fetch with redirect/stall, halt on range exit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FETCH_BOOT;
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0;
      req_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH_BOOT: begin
          state_q <= FETCH_RUN;
        end
        FETCH_RUN: begin
          if (branch_taken_i) begin
            pc_q        <= target_aligned;
            req_valid_q <= 1'b0;
          end else if (stall_i) begin
            // hold everything so decode sees a stable instruction
            pc_q <= pc_q;
          end else if (!in_range) begin
            state_q     <= FETCH_HALT;
            req_valid_q <= 1'b0;
          end else begin
            pc_q        <= pc_q + 32'(WORD_BYTES);
            req_pc_q    <= pc_q;
            req_valid_q <= 1'b1;
          end
        end
        FETCH_HALT: begin
          req_valid_q <= 1'b0;
          if (branch_taken_i && target_in_range) begin
            pc_q    <= target_aligned;
            state_q <= FETCH_RUN;
          end
        end
        default: begin
          state_q     <= FETCH_BOOT;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // An instruction counts as fetched once decode takes it
  assign fetch_count_d = (req_valid_q & ~stall_i) ? fetch_count_q + 32'd1 : fetch_count_q;

  // Accepted-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        rd_en;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc8;
  logic        if_valid;
  logic        halted;
  logic [31:0] fcount;

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem [0:127];

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(512),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .stall_i            (stall),
    .branch_taken_i     (br),
    .branch_target_i    (tgt),
    .instr_i            (instr),
    .pc_o               (pc),
    .instr_mem_read_en_o(rd_en),
    .if_instr_o         (if_instr),
    .if_pc_o            (if_pc),
    .if_pc_plus8_o      (if_pc8),
    .if_valid_o         (if_valid),
    .halted_o           (halted),
    .fetch_count_o      (fcount)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A0_1001;
    if (a == 32'h4) return 32'hE281_1001;
    return {16'hA500, a[15:0]};
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = word_at(32'(i * 4));
    instr = 32'h0;
  end

  // synchronous instruction memory: data one cycle after an enabled read
  always @(posedge clk) begin
    if (rd_en) instr <= mem[pc[8:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every instruction decode accepts must match the scoreboard head
  initial begin
    logic [31:0] e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (!done && rst_n && if_valid && !stall) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_fetch: got pc %h expected no instruction", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", if_pc, e);
          chk("sb_instr", if_instr, word_at(e));
          chk("sb_pc8", if_pc8, e + 32'd8);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; stall = 0; br = 0; tgt = 0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_rden", 32'(rd_en), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", fcount, 32'd0);
    // N0: release, BOOT cycle issues nothing
    @(negedge clk); rst_n = 1; #3;
    chk("boot_rden", 32'(rd_en), 32'd0);
    // N1: first read at RESET_PC
    @(negedge clk); #3;
    chk("first_rden", 32'(rd_en), 32'd1);
    chk("first_pc", pc, 32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    // N2
    @(negedge clk); #3;
    chk("n2_pc8", if_pc8, 32'd8);
    // N3..N5: stall while word 4 is presented
    @(negedge clk); stall = 1; #3;
    chk("stall_ifpc", if_pc, 32'h4);
    chk("stall_rden", 32'(rd_en), 32'd0);
    repeat (2) begin
      @(negedge clk); #3;
      chk("stall_hold_pc", if_pc, 32'h4);
      chk("stall_hold_valid", 32'(if_valid), 32'd1);
      chk("stall_hold_instr", if_instr, 32'hE281_1001);
      chk("stall_hold_rden", 32'(rd_en), 32'd0);
      chk("stall_hold_count", fcount, 32'd1);
      chk("stall_hold_pco", pc, 32'h8);
    end
    // N6: resume at 8
    @(negedge clk); stall = 0; #3;
    chk("resume_rden", 32'(rd_en), 32'd1);
    chk("resume_pc", pc, 32'h8);
    // N7: branch to 0x41 under stall squashes word 8
    @(negedge clk); stall = 1; br = 1; tgt = 32'h41; #3;
    chk("brst_ifpc", if_pc, 32'h8);
    chk("brst_rden", 32'(rd_en), 32'd0);
    // N8
    @(negedge clk); stall = 0; br = 0; #3;
    chk("squash_valid", 32'(if_valid), 32'd0);
    chk("branch_pc", pc, 32'h40);
    exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
    // N9
    @(negedge clk); #3;
    chk("br_land_valid", 32'(if_valid), 32'd1);
    chk("br_land_pc", if_pc, 32'h40);
    // N10
    @(negedge clk);
    // N11: redirect near top of memory
    @(negedge clk); br = 1; tgt = 32'h1F0; #3;
    chk("br2_rden", 32'(rd_en), 32'd0);
    // N12
    @(negedge clk); br = 0; #3;
    chk("br2_valid", 32'(if_valid), 32'd0);
    chk("br2_pc", pc, 32'h1F0);
    exp_q.push_back(32'h1F0); exp_q.push_back(32'h1F4);
    exp_q.push_back(32'h1F8); exp_q.push_back(32'h1FC);
    // N13..N15
    repeat (3) @(negedge clk);
    // N16: last word presented, pc past the end
    @(negedge clk); #3;
    chk("last_ifpc", if_pc, 32'h1FC);
    chk("end_rden", 32'(rd_en), 32'd0);
    chk("end_pc", pc, 32'h200);
    // N17
    @(negedge clk); #3;
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_rden", 32'(rd_en), 32'd0);
    chk("halt_valid", 32'(if_valid), 32'd0);
    // N18: branch out of HALT
    @(negedge clk); br = 1; tgt = 32'h0; #3;
    chk("halt_br_flag", 32'(halted), 32'd1);
    chk("halt_br_rden", 32'(rd_en), 32'd0);
    // N19
    @(negedge clk); br = 0; #3;
    chk("unhalt_flag", 32'(halted), 32'd0);
    chk("unhalt_rden", 32'(rd_en), 32'd1);
    chk("unhalt_pc", pc, 32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    // N20
    @(negedge clk); #3;
    chk("count9", fcount, 32'd9);
    // N21: read of 8 goes in flight
    @(negedge clk); #3;
    chk("inflight_rden", 32'(rd_en), 32'd1);
    // N22: reset mid-operation
    @(negedge clk); rst_n = 0; #3;
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_count", fcount, 32'd0);
    chk("mid_rst_instr", if_instr, NOP);
    chk("mid_rst_rden", 32'(rd_en), 32'd0);
    // N23
    @(negedge clk); rst_n = 1; #3;
    chk("reboot_rden", 32'(rd_en), 32'd0);
    chk("reboot_valid", 32'(if_valid), 32'd0);
    // N24
    @(negedge clk); #3;
    chk("refetch_rden", 32'(rd_en), 32'd1);
    chk("refetch_pc", pc, 32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    // N25, N26, then freeze with a stall
    repeat (2) @(negedge clk);
    @(negedge clk); stall = 1;
    repeat (2) @(negedge clk);
    #3;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
